// File: rtl/mac_rx_filter.sv
// GMII receive filter and frame store: checks preamble/SFD, FCS, length and
// address/EtherType, commits good frames into a circular byte buffer with a
// companion length FIFO, and streams committed frames out on valid/ready.
module mac_rx_filter #(
    parameter int unsigned BUF_ADDR_BITS = 12,
    parameter int unsigned LEN_FIFO_BITS = 4,
    parameter int unsigned NUM_MAC       = 4,
    parameter int unsigned MIN_FRM       = 64,
    parameter int unsigned MAX_FRM       = 1518,
    parameter int unsigned CNT_W         = 16
) (
    input  logic                     GMII_RX_CLK,
    input  logic                     reset_n,
    input  logic [7:0]               gmii_rxd,
    input  logic                     gmii_rx_dv,
    input  logic                     gmii_rx_er,
    input  logic [48*NUM_MAC-1:0]    mac_table,
    input  logic [NUM_MAC-1:0]       mac_en,
    input  logic                     accept_bcast,
    input  logic                     promisc,
    input  logic [15:0]              type_filter,
    input  logic                     type_filter_en,
    output logic [7:0]               m_data,
    output logic [BUF_ADDR_BITS-1:0] m_len,
    output logic                     m_last,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [CNT_W-1:0]         cnt_ok,
    output logic [CNT_W-1:0]         cnt_crc_err,
    output logic [CNT_W-1:0]         cnt_filt_drop,
    output logic [CNT_W-1:0]         cnt_fmt_err,
    output logic [CNT_W-1:0]         cnt_ovf_drop
);
    localparam int unsigned AW    = BUF_ADDR_BITS;
    localparam int unsigned PW    = AW + 1;
    localparam int unsigned LW    = LEN_FIFO_BITS;
    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned LDEP  = 1 << LW;
    localparam logic [15:0] MIN_L = 16'(MIN_FRM);
    localparam logic [15:0] MAX_L = 16'(MAX_FRM);
    localparam logic [31:0] RESIDUE = 32'hC704DD7B;

    typedef enum logic [2:0] {IDLE, PRE, DATA, DROP, COMMIT} rx_state_t;
    rx_state_t state, state_nx;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] lf_mem [LDEP];

    logic [PW-1:0] wr_ptr, commit_ptr, frame_start, rd_ptr, commit_end;
    logic [LW:0]   lf_wr, lf_rd;
    logic [15:0]   byte_cnt;
    logic [2:0]    pre_cnt;
    logic [31:0]   crc;
    logic [39:0]   shreg;
    logic          ovf, er_seen, dv_q;
    logic [AW-1:0] tx_idx, lf_head, rd_base;

    logic dst_hit, type_bad, buf_full, lf_full, lf_empty, data_beat, mem_we;
    logic start, commit_ok, rollback;
    logic inc_ok, inc_crc, inc_filt, inc_fmt, inc_ovf;
    logic [47:0] dst_word;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int unsigned i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    function automatic logic [31:0] rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int unsigned i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    // Address/type filter decisions, taken on the 6th and 14th data bytes as they arrive
    always_comb begin
        dst_word = {shreg, gmii_rxd};
        dst_hit  = promisc || (accept_bcast && dst_word == '1);
        for (int unsigned i = 0; i < NUM_MAC; i++)
            if (mac_en[i] && mac_table[48*i +: 48] == dst_word) dst_hit = 1'b1;
        type_bad   = type_filter_en && ({shreg[7:0], gmii_rxd} != type_filter);
        buf_full   = (wr_ptr - rd_ptr) == PW'(DEPTH);
        lf_empty   = lf_wr == lf_rd;
        lf_full    = (lf_wr[LW] != lf_rd[LW]) && (lf_wr[LW-1:0] == lf_rd[LW-1:0]);
        data_beat  = (state == DATA) && gmii_rx_dv;
        mem_we     = data_beat && !ovf && !buf_full;
        commit_end = frame_start + PW'(byte_cnt) - PW'(4);
        lf_head    = lf_mem[lf_rd[LW-1:0]];
        rd_base    = rd_ptr[AW-1:0];
    end

    // RX state register
    always_ff @(posedge GMII_RX_CLK or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // RX next state and per-frame outcome (exactly one counter bump per frame)
    always_comb begin
        state_nx  = state;
        start     = 1'b0;
        commit_ok = 1'b0;
        inc_ok    = 1'b0;
        inc_crc   = 1'b0;
        inc_filt  = 1'b0;
        inc_fmt   = 1'b0;
        inc_ovf   = 1'b0;
        unique case (state)
            IDLE: begin
                // a dv that was already high (reset mid-frame) is ignored until it drops
                if (gmii_rx_dv && !dv_q) begin
                    if (gmii_rxd == 8'h55 && !gmii_rx_er) state_nx = PRE;
                    else begin state_nx = DROP; inc_fmt = 1'b1; end
                end
            end
            PRE: begin
                if (!gmii_rx_dv) begin state_nx = IDLE; inc_fmt = 1'b1; end
                else if (gmii_rx_er) begin state_nx = DROP; inc_fmt = 1'b1; end
                else if (gmii_rxd == 8'h55) begin
                    if (pre_cnt == 3'd7) begin state_nx = DROP; inc_fmt = 1'b1; end
                end
                else if (gmii_rxd == 8'hD5) begin state_nx = DATA; start = 1'b1; end
                else begin state_nx = DROP; inc_fmt = 1'b1; end
            end
            DATA: begin
                if (!gmii_rx_dv) state_nx = COMMIT;
                else if (byte_cnt == 16'd5 && !dst_hit) begin state_nx = DROP; inc_filt = 1'b1; end
                else if (byte_cnt == 16'd13 && type_bad) begin state_nx = DROP; inc_filt = 1'b1; end
            end
            DROP: begin
                if (!gmii_rx_dv) state_nx = IDLE;
            end
            COMMIT: begin
                state_nx = IDLE;
                if (ovf || lf_full) inc_ovf = 1'b1;
                else if (er_seen || byte_cnt < MIN_L || byte_cnt > MAX_L) inc_fmt = 1'b1;
                else if (rev32(crc) != RESIDUE) inc_crc = 1'b1;
                else begin inc_ok = 1'b1; commit_ok = 1'b1; end
            end
            default: state_nx = IDLE;
        endcase
        rollback = (state_nx == DROP) || (state == DROP) || (state == COMMIT && !commit_ok);
    end

    // RX datapath: CRC, byte count, write/commit pointers, length FIFO push
    always_ff @(posedge GMII_RX_CLK or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            commit_ptr  <= '0;
            frame_start <= '0;
            byte_cnt    <= '0;
            pre_cnt     <= '0;
            crc         <= '1;
            shreg       <= '0;
            ovf         <= 1'b0;
            er_seen     <= 1'b0;
            dv_q        <= 1'b1;
            lf_wr       <= '0;
        end else begin
            dv_q <= gmii_rx_dv;
            if (state == IDLE) pre_cnt <= 3'd1;
            else if (state == PRE && gmii_rxd == 8'h55) pre_cnt <= pre_cnt + 3'd1;
            if (start) begin
                frame_start <= commit_ptr;
                byte_cnt    <= '0;
                crc         <= '1;
                ovf         <= 1'b0;
                er_seen     <= 1'b0;
            end
            if (data_beat) begin
                crc   <= crc_byte(crc, gmii_rxd);
                shreg <= {shreg[31:0], gmii_rxd};
                if (byte_cnt != '1) byte_cnt <= byte_cnt + 16'd1;
                if (gmii_rx_er) er_seen <= 1'b1;
                if (!ovf) begin
                    if (buf_full) ovf <= 1'b1;
                    else          wr_ptr <= wr_ptr + PW'(1);
                end
            end
            // rollback overrides any write-pointer advance made in the same cycle
            if (rollback) wr_ptr <= commit_ptr;
            if (commit_ok) begin
                commit_ptr <= commit_end;
                wr_ptr     <= commit_end;
                lf_wr      <= lf_wr + (LW+1)'(1);
            end
        end
    end

    // Buffer and length FIFO storage (no reset)
    always_ff @(posedge GMII_RX_CLK) begin
        if (mem_we)    mem[wr_ptr[AW-1:0]] <= gmii_rxd;
        if (commit_ok) lf_mem[lf_wr[LW-1:0]] <= AW'(byte_cnt - 16'd4);
    end

    // TX first-word-fall-through: load head frame, advance per transfer, free on last
    always_ff @(posedge GMII_RX_CLK or negedge reset_n) begin
        if (!reset_n) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            m_data  <= '0;
            m_len   <= '0;
            tx_idx  <= '0;
            rd_ptr  <= '0;
            lf_rd   <= '0;
        end else if (!m_valid) begin
            if (!lf_empty) begin
                m_valid <= 1'b1;
                m_len   <= lf_head;
                m_data  <= mem[rd_base];
                m_last  <= lf_head == AW'(1);
                tx_idx  <= '0;
            end
        end else if (m_ready) begin
            if (m_last) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
                rd_ptr  <= rd_ptr + PW'(m_len);
                lf_rd   <= lf_rd + (LW+1)'(1);
            end else begin
                tx_idx <= tx_idx + AW'(1);
                m_data <= mem[rd_base + tx_idx + AW'(1)];
                m_last <= (tx_idx + AW'(2)) == m_len;
            end
        end
    end

    // Saturating statistics
    always_ff @(posedge GMII_RX_CLK or negedge reset_n) begin
        if (!reset_n) begin
            cnt_ok        <= '0;
            cnt_crc_err   <= '0;
            cnt_filt_drop <= '0;
            cnt_fmt_err   <= '0;
            cnt_ovf_drop  <= '0;
        end else begin
            if (inc_ok   && cnt_ok        != '1) cnt_ok        <= cnt_ok + 1'b1;
            if (inc_crc  && cnt_crc_err   != '1) cnt_crc_err   <= cnt_crc_err + 1'b1;
            if (inc_filt && cnt_filt_drop != '1) cnt_filt_drop <= cnt_filt_drop + 1'b1;
            if (inc_fmt  && cnt_fmt_err   != '1) cnt_fmt_err   <= cnt_fmt_err + 1'b1;
            if (inc_ovf  && cnt_ovf_drop  != '1) cnt_ovf_drop  <= cnt_ovf_drop + 1'b1;
        end
    end

endmodule

// File: tb/tb_mac_rx_filter.sv
// Scoreboard bench for mac_rx_filter: frames are classified by a reference
// model when issued, expected output bytes are queued, and a monitor checks
// every transfer independently of the stimulus.
module tb_mac_rx_filter;
    localparam int AW = 12;
    localparam int NM = 4;
    localparam int CW = 16;
    localparam int DEPTH = 4096;
    localparam int LDEPTH = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #4 clk = ~clk;

    logic [7:0]      rxd;
    logic            dv, er;
    logic [47:0]     macs [NM];
    logic [48*NM-1:0] mac_table;
    logic [NM-1:0]   mac_en;
    logic            accept_bcast, promisc, type_filter_en;
    logic [15:0]     type_filter;
    logic [7:0]      m_data;
    logic [AW-1:0]   m_len;
    logic            m_last, m_valid, m_ready;
    logic [CW-1:0]   cnt_ok, cnt_crc, cnt_filt, cnt_fmt, cnt_ovf;

    assign mac_table = {macs[3], macs[2], macs[1], macs[0]};

    mac_rx_filter #(
        .BUF_ADDR_BITS(12), .LEN_FIFO_BITS(4), .NUM_MAC(4),
        .MIN_FRM(64), .MAX_FRM(1518), .CNT_W(16)
    ) dut (
        .GMII_RX_CLK(clk), .reset_n(rst_n),
        .gmii_rxd(rxd), .gmii_rx_dv(dv), .gmii_rx_er(er),
        .mac_table(mac_table), .mac_en(mac_en),
        .accept_bcast(accept_bcast), .promisc(promisc),
        .type_filter(type_filter), .type_filter_en(type_filter_en),
        .m_data(m_data), .m_len(m_len), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
        .cnt_ok(cnt_ok), .cnt_crc_err(cnt_crc), .cnt_filt_drop(cnt_filt),
        .cnt_fmt_err(cnt_fmt), .cnt_ovf_drop(cnt_ovf)
    );

    typedef struct {
        logic [7:0]    data;
        logic [AW-1:0] len;
        logic          last;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e;
    logic [7:0] frm[$];
    int checks = 0, passes = 0;
    int m_ok = 0, m_crc = 0, m_filt = 0, m_fmt = 0, m_ovf = 0;
    int m_used = 0, m_frames = 0;
    int rdy_mode = 1;
    logic       hold = 1'b0;
    logic [7:0] hold_data = '0;

    task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    endtask

    function automatic logic [31:0] crc32(input int upto);
        logic [31:0] c;
        logic fb;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < upto; i++)
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ frm[i][b];
                c = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        return ~c;
    endfunction

    task automatic build_frame(input logic [47:0] dst, input logic [15:0] etype, input int plen, input bit bad_fcs);
        logic [31:0] fcs;
        logic [47:0] src;
        src = 48'h02123456789A;
        frm.delete();
        for (int i = 5; i >= 0; i--) frm.push_back(dst[8*i +: 8]);
        for (int i = 5; i >= 0; i--) frm.push_back(src[8*i +: 8]);
        frm.push_back(etype[15:8]);
        frm.push_back(etype[7:0]);
        for (int i = 0; i < plen; i++) frm.push_back(8'($urandom));
        fcs = crc32(frm.size());
        if (bad_fcs) fcs = fcs ^ (32'd1 << $urandom_range(0, 31));
        for (int i = 0; i < 4; i++) frm.push_back(fcs[8*i +: 8]);
    endtask

    // Reference classification of the frame in frm, from the receive rules
    task automatic expect_frame(input int er_idx);
        int n;
        logic [47:0] dst;
        logic [15:0] etype;
        logic [31:0] fcs;
        bit dst_ok;
        n = frm.size();
        dst = {frm[0], frm[1], frm[2], frm[3], frm[4], frm[5]};
        etype = {frm[12], frm[13]};
        dst_ok = promisc || (accept_bcast && dst == 48'hFFFFFFFFFFFF);
        for (int i = 0; i < NM; i++) if (mac_en[i] && macs[i] == dst) dst_ok = 1;
        fcs = {frm[n-1], frm[n-2], frm[n-3], frm[n-4]};
        if (n >= 6 && !dst_ok) m_filt++;
        else if (n >= 14 && type_filter_en && etype != type_filter) m_filt++;
        else if (m_frames >= LDEPTH || m_used + n > DEPTH) m_ovf++;
        else if (er_idx >= 0 || n < 64 || n > 1518) m_fmt++;
        else if (crc32(n - 4) != fcs) m_crc++;
        else begin
            m_ok++;
            m_used += n - 4;
            m_frames++;
            for (int i = 0; i < n - 4; i++) begin
                e.data = frm[i];
                e.len  = AW'(n - 4);
                e.last = (i == n - 5);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic idle(input int c);
        repeat (c) @(posedge clk);
    endtask

    task automatic drive(input logic [7:0] d, input logic v, input logic r);
        @(posedge clk);
        #1;
        rxd = d; dv = v; er = r;
    endtask

    task automatic send_raw(input int npre, input int er_idx, input int abort_at);
        for (int i = 0; i < npre; i++) drive(8'h55, 1'b1, 1'b0);
        drive(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < frm.size(); i++) begin
            drive(frm[i], 1'b1, i == er_idx);
            if (i == abort_at) rst_n = 1'b0;
            if (i == abort_at + 3) rst_n = 1'b1;
        end
        drive(8'h00, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input int npre, input int er_idx);
        expect_frame(er_idx);
        send_raw(npre, er_idx, -1);
        idle(12);
    endtask

    task automatic check_counters(input string tag);
        chk({tag, "_cnt_ok"},   int'(cnt_ok)   == m_ok,   cnt_ok,   m_ok);
        chk({tag, "_cnt_crc"},  int'(cnt_crc)  == m_crc,  cnt_crc,  m_crc);
        chk({tag, "_cnt_filt"}, int'(cnt_filt) == m_filt, cnt_filt, m_filt);
        chk({tag, "_cnt_fmt"},  int'(cnt_fmt)  == m_fmt,  cnt_fmt,  m_fmt);
        chk({tag, "_cnt_ovf"},  int'(cnt_ovf)  == m_ovf,  cnt_ovf,  m_ovf);
    endtask

    task automatic wait_drain(input string tag);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 20000) begin
            @(posedge clk);
            t++;
        end
        chk({tag, "_drain"}, exp_q.size() == 0, exp_q.size(), 0);
        idle(4);
    endtask

    // Sink ready pattern
    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            m_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
        end
    end

    // Output monitor: hold behaviour and byte-by-byte scoreboard comparison
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) hold = 1'b0;
            else begin
                if (hold)
                    chk("hold_stable", m_valid && m_data == hold_data, {m_valid, m_data}, {1'b1, hold_data});
                hold = m_valid && !m_ready;
                hold_data = m_data;
                if (m_valid && m_ready) begin
                    chk("output_expected", exp_q.size() > 0, {m_last, m_len, m_data}, exp_q.size());
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("out_byte", m_data == e.data && m_len == e.len && m_last == e.last,
                            {m_last, m_len, m_data}, {e.last, e.len, e.data});
                        if (e.last) begin
                            m_used -= int'(e.len);
                            m_frames--;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #700us;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int lat, n, er_idx, r;
        logic [47:0] dst;
        logic [15:0] ty;
        rst_n = 1'b0;
        rxd = '0; dv = 1'b0; er = 1'b0;
        macs[0] = 48'h021122334455;
        macs[1] = 48'h02AABBCCDD01;
        macs[2] = 48'h020000000007;
        macs[3] = 48'h020000000008;
        mac_en = 4'b0111;
        accept_bcast = 1'b1; promisc = 1'b0;
        type_filter = 16'hAA55; type_filter_en = 1'b1;
        idle(5);
        #1 rst_n = 1'b1;
        idle(3);

        chk("reset_m_valid", m_valid == 1'b0, m_valid, 0);
        chk("reset_m_last", m_last == 1'b0, m_last, 0);
        chk("reset_m_data", m_data == 8'h00, m_data, 0);
        check_counters("reset");

        // Good 64-byte frame, plus first-byte latency
        build_frame(macs[0], 16'hAA55, 46, 0);
        expect_frame(-1);
        send_raw(7, -1, -1);
        lat = 0;
        while (!m_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        chk("first_byte_latency", m_valid && lat <= 5, lat, 5);
        wait_drain("good64");
        check_counters("good64");

        // Same frame with a corrupted FCS, then a clean frame
        build_frame(macs[0], 16'hAA55, 46, 1);
        send_frame(7, -1);
        build_frame(macs[1], 16'hAA55, 50, 0);
        send_frame(1, -1);
        wait_drain("crc");
        check_counters("crc");

        // Address filtering: unknown, disabled entry, promiscuous, broadcast
        build_frame(48'h020000000009, 16'hAA55, 46, 0);
        send_frame(7, -1);
        build_frame(macs[3], 16'hAA55, 46, 0);
        send_frame(7, -1);
        promisc = 1'b1;
        build_frame(48'h020000000009, 16'hAA55, 46, 0);
        send_frame(7, -1);
        promisc = 1'b0;
        build_frame(48'hFFFFFFFFFFFF, 16'hAA55, 46, 0);
        send_frame(7, -1);
        accept_bcast = 1'b0;
        build_frame(48'hFFFFFFFFFFFF, 16'hAA55, 46, 0);
        send_frame(7, -1);
        accept_bcast = 1'b1;
        build_frame(macs[2], 16'h0800, 46, 0);
        send_frame(7, -1);
        type_filter_en = 1'b0;
        build_frame(macs[2], 16'h0800, 46, 0);
        send_frame(7, -1);
        type_filter_en = 1'b1;
        wait_drain("filter");
        check_counters("filter");

        // Length limits, receive error, bad preambles, maximum-size frame
        build_frame(macs[0], 16'hAA55, 42, 0);
        send_frame(7, -1);
        build_frame(macs[0], 16'hAA55, 1504, 0);
        send_frame(7, -1);
        build_frame(macs[0], 16'hAA55, 46, 0);
        send_frame(7, 30);
        build_frame(macs[0], 16'hAA55, 46, 0);
        m_fmt++;
        send_raw(8, -1, -1);
        idle(12);
        m_fmt++;
        send_raw(0, -1, -1);
        idle(12);
        build_frame(macs[0], 16'hAA55, 1500, 0);
        send_frame(3, -1);
        wait_drain("format");
        check_counters("format");

        // Buffer overflow with the sink stalled
        rdy_mode = 0;
        for (int i = 0; i < 3; i++) begin
            build_frame(macs[1], 16'hAA55, 1500, 0);
            send_frame(7, -1);
        end
        build_frame(macs[1], 16'hAA55, 46, 0);
        send_frame(7, -1);
        check_counters("buf_ovf");
        rdy_mode = 1;
        wait_drain("buf_ovf");

        // Length FIFO overflow with the sink stalled
        rdy_mode = 0;
        for (int i = 0; i < LDEPTH + 1; i++) begin
            build_frame(macs[0], 16'hAA55, 46, 0);
            send_frame(7, -1);
        end
        check_counters("lf_ovf");
        rdy_mode = 2;
        wait_drain("lf_ovf");
        rdy_mode = 1;

        // Reset in the middle of a frame
        build_frame(macs[0], 16'hAA55, 46, 0);
        send_raw(7, -1, 30);
        idle(12);
        exp_q.delete();
        m_ok = 0; m_crc = 0; m_filt = 0; m_fmt = 0; m_ovf = 0;
        m_used = 0; m_frames = 0;
        chk("midreset_m_valid", m_valid == 1'b0, m_valid, 0);
        check_counters("midreset");
        build_frame(macs[0], 16'hAA55, 46, 0);
        send_frame(7, -1);
        wait_drain("after_reset");
        check_counters("after_reset");

        // Randomized traffic
        rdy_mode = 2;
        for (int k = 0; k < 40; k++) begin
            promisc = ($urandom_range(0, 9) == 0);
            accept_bcast = 1'($urandom_range(0, 1));
            type_filter_en = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 5);
            if (r < 4) dst = macs[r];
            else if (r == 4) dst = 48'hFFFFFFFFFFFF;
            else dst = {8'h02, 8'($urandom), 32'($urandom)};
            ty = ($urandom_range(0, 3) != 0) ? 16'hAA55 : 16'($urandom);
            build_frame(dst, ty, $urandom_range(0, 150), $urandom_range(0, 6) == 0);
            n = frm.size();
            er_idx = ($urandom_range(0, 19) == 0) ? $urandom_range(0, n - 1) : -1;
            send_frame($urandom_range(1, 7), er_idx);
            wait_drain("random");
        end
        check_counters("random");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
